// File: rtl/instr_register_pkg.sv
// Shared types and constants for the instruction register and its sequencer.
package instr_register_pkg;

    localparam int DEPTH = 32;

    typedef enum logic [2:0] {
        ZERO,
        PASSA,
        PASSB,
        ADD,
        SUB,
        MULT,
        DIV,
        MOD
    } opcode_t;

    typedef logic signed [31:0] operand_t;
    typedef logic        [4:0]  address_t;
    typedef logic signed [63:0] result_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

endpackage

// File: rtl/iw_alu.sv
// Combinational arithmetic for one instruction word; operands widened to 64 bits first.
module iw_alu
    import instr_register_pkg::*;
(
    input  instruction_t iw,
    output result_t      result,
    output logic         div_err
);

    result_t a;
    result_t b;

    always_comb begin
        a       = {{32{iw.op_a[31]}}, iw.op_a};
        b       = {{32{iw.op_b[31]}}, iw.op_b};
        result  = '0;
        div_err = 1'b0;
        case (iw.opc)
            ZERO:  result = '0;
            PASSA: result = a;
            PASSB: result = b;
            ADD:   result = a + b;
            SUB:   result = a - b;
            MULT:  result = a * b;
            DIV: begin
                if (b == '0) div_err = 1'b1;
                else         result  = a / b;
            end
            MOD: begin
                if (b == '0) div_err = 1'b1;
                else         result  = a % b;
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// Walks a range of instruction register entries, executing each and handing
// the result to a consumer over a valid/ready handshake.
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | waiting for start
// S_FETCH | capture instruction_word at read_pointer
// S_EXEC  | register ALU result, raise res_valid
// S_HOLD  | present result until res_ready, then advance
// S_DONE  | one-cycle done pulse, start ignored
module instr_sequencer
    import instr_register_pkg::*;
#(
    parameter int DEPTH = instr_register_pkg::DEPTH
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  address_t     start_ptr,
    input  logic [5:0]   num_instr,
    output address_t     read_pointer,
    input  instruction_t instruction_word,
    output logic         res_valid,
    input  logic         res_ready,
    output result_t      result,
    output opcode_t      res_opc,
    output address_t     res_ptr,
    output logic         div_err,
    output logic         busy,
    output logic         done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_HOLD,
        S_DONE
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [5:0]   count;
    instruction_t ir;
    result_t      alu_result;
    logic         alu_div_err;
    address_t     next_ptr;

    logic ld_start;
    logic ld_ir;
    logic ld_res;
    logic accept;

    iw_alu u_alu (
        .iw      (ir),
        .result  (alu_result),
        .div_err (alu_div_err)
    );

    assign next_ptr = (read_pointer == address_t'(DEPTH - 1)) ? '0 : read_pointer + 5'd1;
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ld_start  = 1'b0;
        ld_ir     = 1'b0;
        ld_res    = 1'b0;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    ld_start  = 1'b1;
                    state_nxt = (num_instr == 6'd0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                ld_ir     = 1'b1;
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                ld_res    = 1'b1;
                state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (res_ready) begin
                    accept    = 1'b1;
                    // count still holds the entry being accepted
                    state_nxt = (count == 6'd1) ? S_DONE : S_FETCH;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            read_pointer <= '0;
            count        <= '0;
            ir           <= '0;
            result       <= '0;
            res_opc      <= ZERO;
            res_ptr      <= '0;
            res_valid    <= 1'b0;
            div_err      <= 1'b0;
        end else begin
            if (ld_start) begin
                read_pointer <= start_ptr;
                count        <= num_instr;
            end
            if (ld_ir) ir <= instruction_word;
            if (ld_res) begin
                result    <= alu_result;
                res_opc   <= ir.opc;
                res_ptr   <= read_pointer;
                div_err   <= alu_div_err;
                res_valid <= 1'b1;
            end
            if (accept) begin
                res_valid    <= 1'b0;
                read_pointer <= next_ptr;
                count        <= count - 6'd1;
            end
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed corner cases plus random
// sequences checked against an arithmetic reference model.
module tb_instr_sequencer;
    import instr_register_pkg::*;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    address_t     start_ptr;
    logic [5:0]   num_instr;
    address_t     read_pointer;
    instruction_t instruction_word;
    logic         res_valid;
    logic         res_ready;
    result_t      result;
    opcode_t      res_opc;
    address_t     res_ptr;
    logic         div_err;
    logic         busy;
    logic         done;

    instruction_t mem [32];
    int n_assert = 0;
    int n_fail   = 0;
    longint last_result;
    logic   last_err;

    instr_sequencer dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .start_ptr        (start_ptr),
        .num_instr        (num_instr),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .result           (result),
        .res_opc          (res_opc),
        .res_ptr          (res_ptr),
        .div_err          (div_err),
        .busy             (busy),
        .done             (done)
    );

    assign instruction_word = mem[read_pointer];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint model_res(input instruction_t iw);
        longint a = longint'(iw.op_a);
        longint b = longint'(iw.op_b);
        case (iw.opc)
            PASSA:   return a;
            PASSB:   return b;
            ADD:     return a + b;
            SUB:     return a - b;
            MULT:    return a * b;
            DIV:     return (b == 0) ? 64'sd0 : a / b;
            MOD:     return (b == 0) ? 64'sd0 : a % b;
            default: return 64'sd0;
        endcase
    endfunction

    function automatic logic model_err(input instruction_t iw);
        return (iw.opc == DIV || iw.opc == MOD) && (iw.op_b == 0);
    endfunction

    // Counts edges from the current negedge until res_valid is seen (bounded).
    task automatic wait_valid(input string tag);
        int cyc = 0;
        do begin
            @(posedge clk);
            cyc++;
            #1;
            res_ready = 1'b0;
            start     = 1'b0;
            @(negedge clk);
        end while (!res_valid && cyc < 20);
        check({tag, "_latency"}, 64'(cyc), 64'd3);
    endtask

    task automatic run_seq(input int p, input int n, input int min_stall, input int max_stall);
        int idx;
        int stall;
        instruction_t iw;
        start_ptr = address_t'(p);
        num_instr = 6'(n);
        start     = 1'b1;
        if (n == 0) begin
            @(posedge clk);
            #1 start = 1'b0;
            @(negedge clk);
            check("zero_done", 64'(done), 64'd1);
            check("zero_valid", 64'(res_valid), 64'd0);
            @(posedge clk);
            @(negedge clk);
            check("zero_done_end", 64'(done), 64'd0);
            check("zero_busy_end", 64'(busy), 64'd0);
            check("zero_valid_end", 64'(res_valid), 64'd0);
            return;
        end
        for (int k = 0; k < n; k++) begin
            wait_valid((k == 0) ? "first" : "next");
            idx = (p + k) % 32;
            iw  = mem[idx];
            check("res_valid", 64'(res_valid), 64'd1);
            check("res_ptr", 64'(res_ptr), 64'(idx));
            check("result", 64'(result), 64'(model_res(iw)));
            check("res_opc", 64'(res_opc), 64'(iw.opc));
            check("div_err", 64'(div_err), 64'(model_err(iw)));
            check("done_mid", 64'(done), 64'd0);
            last_result = result;
            last_err    = div_err;
            stall = $urandom_range(max_stall, min_stall);
            for (int s = 0; s < stall; s++) begin
                start     = 1'b1;
                start_ptr = address_t'($urandom);
                @(posedge clk);
                #1 start = 1'b0;
                @(negedge clk);
                check("hold_valid", 64'(res_valid), 64'd1);
                check("hold_result", 64'(result), 64'(model_res(iw)));
                check("hold_opc", 64'(res_opc), 64'(iw.opc));
                check("hold_ptr", 64'(res_ptr), 64'(idx));
                check("hold_rdptr", 64'(read_pointer), 64'(idx));
            end
            res_ready = 1'b1;
            if (k == n - 1) begin
                @(posedge clk);
                #1 res_ready = 1'b0;
                @(negedge clk);
                check("done_pulse", 64'(done), 64'd1);
                check("done_valid", 64'(res_valid), 64'd0);
                start     = 1'b1;
                start_ptr = address_t'($urandom);
                @(posedge clk);
                #1 start = 1'b0;
                @(negedge clk);
                check("done_end", 64'(done), 64'd0);
                check("idle_busy", 64'(busy), 64'd0);
                check("end_rdptr", 64'(read_pointer), 64'((p + n) % 32));
            end
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 32; i++) begin
            mem[i].opc  = opcode_t'($urandom_range(7, 0));
            mem[i].op_a = operand_t'($urandom);
            case ($urandom_range(3, 0))
                0:       mem[i].op_b = '0;
                1:       mem[i].op_b = operand_t'($urandom_range(20, 0)) - 32'sd10;
                default: mem[i].op_b = operand_t'($urandom);
            endcase
        end
    endtask

    initial begin
        logic seen_done;
        logic seen_valid;
        reset_n   = 1'b0;
        start     = 1'b0;
        res_ready = 1'b0;
        start_ptr = '0;
        num_instr = '0;
        fill_random();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_valid", 64'(res_valid), 64'd0);
        check("rst_rdptr", 64'(read_pointer), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_opc", 64'(res_opc), 64'(ZERO));
        check("rst_ptr", 64'(res_ptr), 64'd0);
        check("rst_err", 64'(div_err), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        mem[0] = '{ADD, 32'sd5, -32'sd7};
        run_seq(0, 1, 0, 0);
        check("add_lit", 64'(last_result), 64'hFFFF_FFFF_FFFF_FFFE);

        mem[30] = '{SUB, 32'sd10, 32'sd3};
        mem[31] = '{PASSA, -32'sd4, 32'sd9};
        mem[1]  = '{PASSB, 32'sd1, -32'sd8};
        run_seq(30, 4, 0, 1);

        mem[5] = '{DIV, 32'sd7, 32'sd0};
        mem[6] = '{MOD, -32'sd7, 32'sd2};
        mem[7] = '{MULT, 32'sh7FFF_FFFF, 32'sd2};
        run_seq(5, 1, 0, 0);
        check("div0_res", 64'(last_result), 64'd0);
        check("div0_err", 64'(last_err), 64'd1);
        run_seq(6, 1, 0, 0);
        check("mod_res", 64'(last_result), 64'hFFFF_FFFF_FFFF_FFFF);
        check("mod_err", 64'(last_err), 64'd0);
        run_seq(7, 1, 5, 5);
        check("mult_res", 64'(last_result), 64'h0000_0000_FFFF_FFFE);

        run_seq(3, 0, 0, 0);

        for (int r = 0; r < 8; r++) begin
            fill_random();
            run_seq(int'($urandom_range(31, 0)), int'($urandom_range(8, 1)), 0, 3);
        end
        fill_random();
        run_seq(17, 32, 0, 1);

        // abort from HOLD: outputs must clear without waiting for a clock
        fill_random();
        start_ptr = 5'd10;
        num_instr = 6'd3;
        start     = 1'b1;
        wait_valid("abort");
        #2 reset_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_valid", 64'(res_valid), 64'd0);
        check("abort_result", 64'(result), 64'd0);
        check("abort_opc", 64'(res_opc), 64'(ZERO));
        check("abort_ptr", 64'(res_ptr), 64'd0);
        check("abort_rdptr", 64'(read_pointer), 64'd0);
        check("abort_err", 64'(div_err), 64'd0);
        @(negedge clk);
        reset_n   = 1'b1;
        res_ready = 1'b1;
        seen_done  = 1'b0;
        seen_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            seen_done  = seen_done | done;
            seen_valid = seen_valid | res_valid;
        end
        check("abort_no_done", 64'(seen_done), 64'd0);
        check("abort_no_valid", 64'(seen_valid), 64'd0);
        res_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
